stack_ctrl: RTL and testbench
=============================

# stack_ctrl

Operand-stack controller for the stack calculator. It sits directly upstream of the combinational `ALU`. It holds pushed 32-bit operands in a LIFO, pops the top two when an operation is requested, and drives them onto the ALU `A`/`B`/`op` inputs. On the next clock edge it writes the ALU result `Y` back as the new top of stack. It also keeps sticky overflow and divide-by-zero status for the display/UI layer.

## Interface
- `DEPTH`, default 8: number of stack entries, a power of two, at least 2.
- `WIDTH`, default 32: operand width. It must equal the ALU width.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high; sampled on the rising edge of `clk`.
- `push`  in  1  push `din` onto the stack (qualified by `ready`).
- `din`  in  WIDTH  operand to push.
- `op_valid`  in  1  request an operation (qualified by `ready`).
- `op`  in  4  one-hot operation code: 0001 add, 0010 sub, 0100 mul, 1000 div.
- `clear`  in  1  empty the stack and clear all flags.
- `alu_y`  in  WIDTH  ALU result `Y`.
- `alu_ovf`  in  1  ALU `overflow`.
- `alu_a`  out  WIDTH  registered ALU operand `A` (second from top).
- `alu_b`  out  WIDTH  registered ALU operand `B` (top).
- `alu_op`  out  4  registered ALU op. It is 4'b0000 whenever the controller is not in EXEC.
- `ready`  out  1  high in IDLE; `push`/`op_valid` are accepted only while it is high.
- `done`  out  1  one-cycle pulse the cycle after a result write-back.
- `top`  out  WIDTH  current top entry; 0 when empty.
- `count`  out  $clog2(DEPTH)+1  number of valid entries.
- `empty`, `full`  out  1 each  count==0 and count==DEPTH.
- `ovf_flag`  out  1  sticky; an add/sub/mul produced `alu_ovf`=1.
- `div0_flag`  out  1  sticky; a div was executed with B==0.
- `err`  out  1  one-cycle pulse on a rejected push or op.

## Operation
- **States.** The controller has two states, IDLE and EXEC. Reset and `clear` both force IDLE.
- **Push in IDLE.** When `push`=1, `din` is written to `stack[count]` and `count` increments.
  - If the stack is full, the push is dropped and `err` pulses.
- **Op in IDLE.** When `op_valid`=1 and `push`=0, `op` is checked, then the state moves to EXEC.
  - `op` must be one-hot-valid; otherwise `err` pulses, the stack is unchanged and the state stays IDLE.
  - `count` must be at least 2; otherwise `err` pulses, the stack is unchanged and the state stays IDLE.
  - On acceptance, `alu_a`←`stack[count-2]`, `alu_b`←`stack[count-1]` and `alu_op`←`op` are registered.
- **Simultaneous push and op_valid in IDLE.** The push executes and the op is not accepted. The requester must hold `op_valid`.
- **EXEC (exactly one cycle).**
  - The ALU computes combinationally from the registered operands.
  - On the next edge, `alu_y` is written to `stack[count-2]`, `count` decrements by 1, `alu_op` returns to 0 and the state returns to IDLE.
- **Flags at write-back.**
  - For add/sub/mul, `alu_ovf`=1 sets `ovf_flag`.
  - For div, `alu_ovf` is ignored. `div0_flag` is set if `alu_b`==0; the stored result is whatever the ALU drives (0).
- **Operand order.** A is the earlier push and B the later one. For example, push 7, push 3, sub gives 4.
- **`clear` (any state, highest priority after `reset`).** It sets `count`=0, clears both sticky flags, sets `alu_op`=0 and goes to IDLE. An EXEC in progress is aborted with no write-back and no `done`.
- **Stack contents.** Entries are not zeroed by reset or clear. Only `count` defines validity, and `top` is forced to 0 when empty.
- **Arithmetic.** No width extension; results are truncated to WIDTH by the ALU.

## Timing
- **Reset values.** `count`=0, `alu_a`=`alu_b`=0, `alu_op`=0, `ready`=1, `done`=0, `err`=0, `ovf_flag`=`div0_flag`=0, `top`=0, `empty`=1, `full`=0.
- **Push.** Accepted at edge N; `top`/`count` are updated after edge N. Back-to-back pushes are allowed every cycle.
- **Op.**
  - Accepted at edge N, after which `ready`=0 and the operands are valid on the `alu_*` ports.
  - Write-back occurs at edge N+1, after which `ready`=1.
  - `done`=1 for the cycle after edge N+1.
  - Op-to-op throughput is 2 cycles.
- **`err`.** Asserted for exactly the cycle after the rejecting edge.
- **`reset` mid-EXEC.** All outputs return to their reset values after that edge, with no write-back.

## Test plan
- Push 7, push 3, op=0010 → `alu_a`=7, `alu_b`=3 during EXEC; then `top`=4, `count`=1, `done` pulses once, `ovf_flag`=0.
- Push 5 only, op=0001 → `err` pulses, `count`=1, `top`=5, `ready` stays 1.
- Push DEPTH+1 values 1..9 with DEPTH=8 → `full`=1, `count`=8, `top`=8, `err` on the 9th push only.
- Push 9, push 0, op=1000 → `top`=0, `div0_flag`=1. Then push 4, push 2, op=1000 → `top`=2, and `div0_flag` stays 1 until `clear`.
- Push 32'hFFFFFFFF, push 1, op=0001 → `top`=0, `ovf_flag`=1. Then op=0011 with `count`=2 → `err`, stack unchanged.
- Push 6, push 2, op=0100, assert `reset` (or `clear`) in the EXEC cycle → `count`=0, `empty`=1, `alu_op`=0, no `done`, `ready`=1 next cycle.

Source files
------------

// File: rtl/stack_ctrl_if.sv
// Operand-stack controller bus: requester/ALU side (master) and controller side (slave).
interface stack_ctrl_if #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic             push;
  logic [WIDTH-1:0] din;
  logic             op_valid;
  logic [3:0]       op;
  logic             clear;
  logic [WIDTH-1:0] alu_y;
  logic             alu_ovf;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [3:0]       alu_op;
  logic             ready;
  logic             done;
  logic [WIDTH-1:0] top;
  logic [CW-1:0]    count;
  logic             empty;
  logic             full;
  logic             ovf_flag;
  logic             div0_flag;
  logic             err;

  modport master (
    output push, din, op_valid, op, clear, alu_y, alu_ovf,
    input  alu_a, alu_b, alu_op, ready, done, top, count, empty, full,
           ovf_flag, div0_flag, err
  );

  modport slave (
    input  push, din, op_valid, op, clear, alu_y, alu_ovf,
    output alu_a, alu_b, alu_op, ready, done, top, count, empty, full,
           ovf_flag, div0_flag, err
  );
endinterface

// File: rtl/stack_ctrl.sv
// LIFO operand stack feeding a combinational ALU; pops two operands per op and
// writes the ALU result back as the new top one cycle later.
module stack_ctrl #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32
) (
  input  logic        clk,
  input  logic        reset,
  stack_ctrl_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [3:0] OP_DIV = 4'b1000;

  typedef enum logic {IDLE, EXEC} state_t;

  state_t           state;
  logic [WIDTH-1:0] stack [DEPTH];
  logic [CW-1:0]    count_q;
  logic [WIDTH-1:0] alu_a_q;
  logic [WIDTH-1:0] alu_b_q;
  logic [3:0]       alu_op_q;
  logic             done_q;
  logic             err_q;
  logic             ovf_q;
  logic             div0_q;

  logic             full_w;
  logic             empty_w;
  logic [AW-1:0]    top_idx;
  logic [AW-1:0]    nos_idx;
  logic [AW-1:0]    push_idx;
  logic             we;
  logic [AW-1:0]    widx;
  logic [WIDTH-1:0] wdata;

  function automatic logic op_is_valid(input logic [3:0] o);
    return (o == 4'b0001) || (o == 4'b0010) || (o == 4'b0100) || (o == 4'b1000);
  endfunction

  assign full_w   = (count_q == CW'(DEPTH));
  assign empty_w  = (count_q == '0);
  assign top_idx  = AW'(count_q - CW'(1));
  assign nos_idx  = AW'(count_q - CW'(2));
  assign push_idx = count_q[AW-1:0];

  // Single write port: either an accepted push or the EXEC write-back.
  always_comb begin
    we    = 1'b0;
    widx  = push_idx;
    wdata = bus.din;
    if (!reset && !bus.clear) begin
      if (state == IDLE && bus.push && !full_w) begin
        we = 1'b1;
      end else if (state == EXEC) begin
        we    = 1'b1;
        widx  = nos_idx;
        wdata = bus.alu_y;
      end
    end
  end

  // Entries carry no reset; count alone defines which ones are valid.
  always_ff @(posedge clk) begin
    if (we) stack[widx] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      count_q  <= '0;
      alu_a_q  <= '0;
      alu_b_q  <= '0;
      alu_op_q <= 4'b0000;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      ovf_q    <= 1'b0;
      div0_q   <= 1'b0;
    end else if (bus.clear) begin
      state    <= IDLE;
      count_q  <= '0;
      alu_op_q <= 4'b0000;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      ovf_q    <= 1'b0;
      div0_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.push) begin
            if (full_w) err_q <= 1'b1;
            else        count_q <= count_q + CW'(1);
          end else if (bus.op_valid) begin
            if (!op_is_valid(bus.op) || count_q < CW'(2)) begin
              err_q <= 1'b1;
            end else begin
              alu_a_q  <= stack[nos_idx];
              alu_b_q  <= stack[top_idx];
              alu_op_q <= bus.op;
              state    <= EXEC;
            end
          end
        end
        EXEC: begin
          count_q  <= count_q - CW'(1);
          alu_op_q <= 4'b0000;
          done_q   <= 1'b1;
          state    <= IDLE;
          // Division reports only a zero divisor; the ALU overflow bit is not meaningful there.
          if (alu_op_q == OP_DIV) begin
            if (alu_b_q == '0) div0_q <= 1'b1;
          end else if (bus.alu_ovf) begin
            ovf_q <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.alu_a     = alu_a_q;
  assign bus.alu_b     = alu_b_q;
  assign bus.alu_op    = alu_op_q;
  assign bus.ready     = (state == IDLE);
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.top       = empty_w ? '0 : stack[top_idx];
  assign bus.count     = count_q;
  assign bus.empty     = empty_w;
  assign bus.full      = full_w;
  assign bus.ovf_flag  = ovf_q;
  assign bus.div0_flag = div0_q;
endmodule

// File: tb/tb_stack_ctrl.sv
// Directed bench for stack_ctrl with a behavioural ALU and a result scoreboard.
module tb_stack_ctrl;
  localparam int DEPTH = 8;
  localparam int WIDTH = 32;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;
  logic [WIDTH-1:0] exp_q[$];

  always #5 clk = ~clk;

  stack_ctrl_if #(.DEPTH(DEPTH), .WIDTH(WIDTH)) bus ();

  stack_ctrl #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // External ALU: unsigned carry/borrow/high-product overflow, div by zero yields 0.
  logic [63:0] prod;
  always_comb begin
    bus.alu_y   = '0;
    bus.alu_ovf = 1'b0;
    prod        = 64'(bus.alu_a) * 64'(bus.alu_b);
    case (bus.alu_op)
      4'b0001: {bus.alu_ovf, bus.alu_y} = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
      4'b0010: begin
        bus.alu_y   = bus.alu_a - bus.alu_b;
        bus.alu_ovf = bus.alu_a < bus.alu_b;
      end
      4'b0100: begin
        bus.alu_y   = prod[31:0];
        bus.alu_ovf = |prod[63:32];
      end
      4'b1000: bus.alu_y = (bus.alu_b == '0) ? '0 : bus.alu_a / bus.alu_b;
      default: ;
    endcase
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_push(input logic [WIDTH-1:0] v);
    bus.push = 1'b1;
    bus.din  = v;
    tick();
    bus.push = 1'b0;
  endtask

  task automatic do_op(input logic [3:0] o);
    bus.op_valid = 1'b1;
    bus.op       = o;
    tick();
    bus.op_valid = 1'b0;
    bus.op       = 4'b0000;
  endtask

  task automatic do_clear();
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
  endtask

  // Waits a bounded number of cycles for done, then checks the top against the queued result.
  task automatic wait_done(input string tag);
    logic seen;
    logic [WIDTH-1:0] e;
    seen = 1'b0;
    for (int k = 0; k < 4 && !seen; k++) begin
      tick();
      if (bus.done === 1'b1) seen = 1'b1;
    end
    chk({tag, "_done_seen"}, 64'(seen), 64'(1));
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk({tag, "_result"}, 64'(bus.top), 64'(e));
    end else begin
      chk({tag, "_queue_nonempty"}, 64'(0), 64'(1));
    end
  endtask

  initial begin
    bus.push = 1'b0; bus.din = '0; bus.op_valid = 1'b0; bus.op = 4'b0000; bus.clear = 1'b0;
    tick(); tick();
    reset = 1'b0;

    chk("rst_count", 64'(bus.count), 64'(0));
    chk("rst_alu_a", 64'(bus.alu_a), 64'(0));
    chk("rst_alu_b", 64'(bus.alu_b), 64'(0));
    chk("rst_alu_op", 64'(bus.alu_op), 64'(0));
    chk("rst_ready", 64'(bus.ready), 64'(1));
    chk("rst_done", 64'(bus.done), 64'(0));
    chk("rst_err", 64'(bus.err), 64'(0));
    chk("rst_flags", 64'({bus.ovf_flag, bus.div0_flag}), 64'(0));
    chk("rst_top", 64'(bus.top), 64'(0));
    chk("rst_empty_full", 64'({bus.empty, bus.full}), 64'(2'b10));

    // 7 - 3
    do_push(32'd7);
    do_push(32'd3);
    chk("sub_pre_top", 64'(bus.top), 64'(3));
    chk("sub_pre_count", 64'(bus.count), 64'(2));
    exp_q.push_back(32'd4);
    do_op(4'b0010);
    chk("sub_ready_exec", 64'(bus.ready), 64'(0));
    chk("sub_alu_a", 64'(bus.alu_a), 64'(7));
    chk("sub_alu_b", 64'(bus.alu_b), 64'(3));
    chk("sub_alu_op", 64'(bus.alu_op), 64'(4'b0010));
    wait_done("sub");
    chk("sub_count", 64'(bus.count), 64'(1));
    chk("sub_ready_back", 64'(bus.ready), 64'(1));
    chk("sub_alu_op_idle", 64'(bus.alu_op), 64'(0));
    chk("sub_ovf", 64'(bus.ovf_flag), 64'(0));
    tick();
    chk("sub_done_once", 64'(bus.done), 64'(0));

    // Op with a single operand
    do_clear();
    do_push(32'd5);
    do_op(4'b0001);
    chk("short_err", 64'(bus.err), 64'(1));
    chk("short_count", 64'(bus.count), 64'(1));
    chk("short_top", 64'(bus.top), 64'(5));
    chk("short_ready", 64'(bus.ready), 64'(1));
    tick();
    chk("short_err_one_cycle", 64'(bus.err), 64'(0));

    // Overfill
    do_clear();
    for (int i = 1; i <= DEPTH + 1; i++) begin
      do_push(WIDTH'(i));
      chk($sformatf("fill_err_%0d", i), 64'(bus.err), 64'(i == DEPTH + 1));
    end
    chk("fill_full", 64'(bus.full), 64'(1));
    chk("fill_count", 64'(bus.count), 64'(DEPTH));
    chk("fill_top", 64'(bus.top), 64'(8));

    // Divide by zero, then a normal divide keeps the sticky flag
    do_clear();
    do_push(32'd9);
    do_push(32'd0);
    exp_q.push_back(32'd0);
    do_op(4'b1000);
    wait_done("div0");
    chk("div0_flag", 64'(bus.div0_flag), 64'(1));
    do_push(32'd4);
    do_push(32'd2);
    exp_q.push_back(32'd2);
    do_op(4'b1000);
    wait_done("div");
    chk("div_count", 64'(bus.count), 64'(2));
    chk("div0_sticky", 64'(bus.div0_flag), 64'(1));
    chk("div_no_ovf", 64'(bus.ovf_flag), 64'(0));
    do_clear();
    chk("div0_cleared", 64'(bus.div0_flag), 64'(0));
    chk("clear_empty", 64'(bus.empty), 64'(1));

    // Add overflow, then an invalid op code
    do_push(32'hFFFF_FFFF);
    do_push(32'd1);
    exp_q.push_back(32'd0);
    do_op(4'b0001);
    wait_done("add_ovf");
    chk("ovf_flag", 64'(bus.ovf_flag), 64'(1));
    do_push(32'd5);
    do_op(4'b0011);
    chk("badop_err", 64'(bus.err), 64'(1));
    chk("badop_count", 64'(bus.count), 64'(2));
    chk("badop_top", 64'(bus.top), 64'(5));
    chk("badop_alu_op", 64'(bus.alu_op), 64'(0));

    // Push and op together: push wins, held op goes next
    do_clear();
    do_push(32'd1);
    do_push(32'd2);
    bus.push = 1'b1; bus.din = 32'd3; bus.op_valid = 1'b1; bus.op = 4'b0001;
    tick();
    bus.push = 1'b0;
    chk("both_count", 64'(bus.count), 64'(3));
    chk("both_ready", 64'(bus.ready), 64'(1));
    exp_q.push_back(32'd5);
    tick();
    bus.op_valid = 1'b0; bus.op = 4'b0000;
    chk("both_alu_ab", 64'({bus.alu_a, bus.alu_b}), {32'd2, 32'd3});
    wait_done("both");
    chk("both_count_after", 64'(bus.count), 64'(2));

    // Multiply
    do_clear();
    do_push(32'd6);
    do_push(32'd7);
    exp_q.push_back(32'd42);
    do_op(4'b0100);
    wait_done("mul");

    // Reset during EXEC aborts the write-back
    do_clear();
    do_push(32'd6);
    do_push(32'd2);
    do_op(4'b0100);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rstx_count", 64'(bus.count), 64'(0));
    chk("rstx_empty", 64'(bus.empty), 64'(1));
    chk("rstx_alu_op", 64'(bus.alu_op), 64'(0));
    chk("rstx_alu_a", 64'(bus.alu_a), 64'(0));
    chk("rstx_done", 64'(bus.done), 64'(0));
    chk("rstx_ready", 64'(bus.ready), 64'(1));
    tick();
    chk("rstx_no_done", 64'(bus.done), 64'(0));

    // Clear during EXEC aborts the write-back
    do_push(32'd6);
    do_push(32'd2);
    do_op(4'b0100);
    chk("clrx_exec", 64'(bus.ready), 64'(0));
    do_clear();
    chk("clrx_count", 64'(bus.count), 64'(0));
    chk("clrx_alu_op", 64'(bus.alu_op), 64'(0));
    chk("clrx_ready", 64'(bus.ready), 64'(1));
    chk("clrx_done", 64'(bus.done), 64'(0));
    tick();
    chk("clrx_no_done", 64'(bus.done), 64'(0));

    chk("scoreboard_drained", 64'(exp_q.size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
